hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle for both MULT and DIV.
// Define HILO_SIGNED_EN to enable signed MULT/DIV; otherwise op[1] is ignored.
module hilo_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              dz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [5:0] LAST = 6'(DATA_W);

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic                  is_div_q, is_div_d;
    logic                  divz_q, divz_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     md_q, md_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                  busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [2*DATA_W-1:0]   fix_res;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_diff;

`ifdef HILO_SIGNED_EN
    logic sgn_q, sgn_d;
    logic neg_a, neg_b;

    assign neg_a = sgn_q & opa_q[DATA_W-1];
    assign neg_b = sgn_q & opb_q[DATA_W-1];
    assign mag_a = neg_a ? -opa_q : opa_q;
    assign mag_b = neg_b ? -opb_q : opb_q;

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_comb begin
        fix_res = acc_q;
        if (!is_div_q) begin
            if (neg_a ^ neg_b) fix_res = -acc_q;
        end else begin
            if (neg_a ^ neg_b) fix_res[DATA_W-1:0] = -acc_q[DATA_W-1:0];
            if (neg_a)         fix_res[2*DATA_W-1:DATA_W] = -acc_q[2*DATA_W-1:DATA_W];
        end
    end
`else
    logic unused_op;

    assign unused_op = &{1'b0, op[1]};
    assign mag_a     = opa_q;
    assign mag_b     = opb_q;
    assign fix_res   = acc_q;
`endif

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, md_q} : '0);
    // Shifted remainder is below 2*divisor, so bit DATA_W of the difference is the borrow.
    assign div_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, md_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        divz_d   = divz_q;
        acc_d    = acc_q;
        md_d     = md_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
`ifdef HILO_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d    = a;
                    opb_d    = b;
                    is_div_d = op[0];
`ifdef HILO_SIGNED_EN
                    sgn_d    = op[1];
`endif
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    busy_d   = 1'b1;
                    if (op[0] && b == '0) begin
                        divz_d  = 1'b1;
                        state_d = FIX;
                    end else begin
                        divz_d  = 1'b0;
                        state_d = CALC;
                    end
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            CALC: begin
                // cnt==0 loads operand magnitudes; cnt 1..DATA_W each produce one bit.
                if (cnt_q == '0) begin
                    acc_d = {{DATA_W{1'b0}}, (is_div_q ? mag_a : mag_b)};
                    md_d  = is_div_q ? mag_b : mag_a;
                end else if (is_div_q) begin
                    if (!div_diff[DATA_W])
                        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                if (divz_q) begin
                    hi_d = '0;
                    lo_d = '0;
                end else begin
                    hi_d = fix_res[2*DATA_W-1:DATA_W];
                    lo_d = fix_res[DATA_W-1:0];
                end
                dz_d    = divz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            acc_q    <= '0;
            md_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
`ifdef HILO_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            acc_q    <= acc_d;
            md_q     <= md_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
`ifdef HILO_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv with an arithmetic reference model of HI/LO results.
// Follows HILO_SIGNED_EN the same way as the design build.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        wr_hi, wr_lo;
    logic [31:0] wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {dz, hi, lo} from plain arithmetic on the operands.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic        sg;
        longint      sx, sy, p, q, r;
        logic [63:0] up;
`ifdef HILO_SIGNED_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[0]) begin
            if (sg) begin
                p = sx * sy;
                return {1'b0, 64'(p)};
            end
            up = {32'b0, x} * {32'b0, y};
            return {1'b0, up};
        end
        if (y == 32'd0) return {1'b1, 64'd0};
        if (sg) begin
            q = sx / sy;
            r = sx % sy;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, x % y, x / y};
    endfunction

    // mode 0: plain; 1: second start + wr_hi during busy; 2: writes alongside start
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
        logic [64:0] r;
        int          lat;
        r   = model(o, x, y);
        lat = (o[0] && y == 32'd0) ? 2 : 35;
        start = 1'b1; op = o; a = x; b = y;
        if (mode == 2) begin
            wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5678;
        end
        step();
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        for (int k = 1; k < lat; k++) begin
            check("busy_high", busy, 1);
            check("done_low", done, 0);
            check("dz_cleared", dz, 0);
            check("hi_hold", hi, m_hi);
            check("lo_hold", lo, m_lo);
            if (mode == 1 && k == 5) begin
                start = 1'b1; op = 2'b01; a = 32'h1111; b = 32'h3;
                wr_hi = 1'b1; wdata = 32'hDEAD;
            end
            step();
            start = 1'b0; wr_hi = 1'b0;
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("hi_result", hi, m_hi);
        check("lo_result", lo, m_lo);
        check("dz_result", dz, {63'd0, r[64]});
        step();
        check("done_once", done, 0);
        check("hi_after", hi, m_hi);
        check("lo_after", lo, m_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          sel;

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        step();
        step();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        rst_n = 1'b1;
        step();

        // MTHI/MTLO together in IDLE, then the same with start
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        step();
        wr_hi = 1'b0; wr_lo = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h1234;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        check("mt_busy", busy, 0);
        do_op(2'b00, 32'd3, 32'd5, 2);

        do_op(2'b10, 32'hFFFFFFFE, 32'd3, 0);
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        do_op(2'b01, 32'd7, 32'd2, 0);
        do_op(2'b01, 32'd5, 32'd0, 0);
        do_op(2'b00, 32'd2, 32'd3, 0);
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(2'b11, 32'd7, 32'd0, 0);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

        // async reset in the middle of a DIVU
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dz", dz, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        do_op(2'b01, 32'd100, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) ry = 32'd0;
            if (sel == 1) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            if (sel == 2) ry = 32'($urandom_range(1, 15));
            if (sel == 3) begin
                wr_hi = 1'($urandom_range(0, 1));
                wr_lo = 1'($urandom_range(0, 1));
                wdata = $urandom;
                step();
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
                wr_hi = 1'b0; wr_lo = 1'b0;
                check("rnd_mt_hi", hi, m_hi);
                check("rnd_mt_lo", lo, m_lo);
            end
            do_op(ro, rx, ry, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
